// File: rtl/mem_if_pkg.sv
// mem_if_pkg
// Shared definitions for the processor-side memoryModule initiator:
//   - cntrl encodings driven towards memoryModule
//   - FSM state type and state constants
//   - packed request record held in the one-entry buffer
// The module parameters ADDR_W / DATA_W of mem_requester are expected to
// equal REQ_ADDR_W / REQ_DATA_W, because the request record is fixed-width.
package mem_if_pkg;

  localparam int REQ_ADDR_W = 8;
  localparam int REQ_DATA_W = 8;

  localparam logic [1:0] CNTRL_NOP   = 2'b00;
  localparam logic [1:0] CNTRL_READ  = 2'b01;
  localparam logic [1:0] CNTRL_WRITE = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_BUSY    = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;

  typedef struct packed {
    logic                  write;
    logic                  indirect;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/mem_requester_req_buffer.sv
// req_buffer
// One-entry holding register between the CPU request handshake and the
// memory-side FSM.
// Ports:
//   clk, clr    clock, asynchronous active-low reset
//   push_valid  request offered
//   push_ready  buffer empty; request taken on push_valid & push_ready
//   push_req    request record offered
//   pop         FSM consumes the held entry this cycle
//   full        an entry is held
//   head        the held entry
module req_buffer
  import mem_if_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic push_valid,
  output logic push_ready,
  input  req_t push_req,
  input  logic pop,
  output logic full,
  output req_t head
);

  assign push_ready = ~full;

  // The pop is applied first: a push in the same cycle leaves the buffer
  // full with the new entry. With push_ready = ~full the two never coincide
  // through the handshake, but the ordering is kept explicit.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      full <= 1'b0;
      head <= '0;
    end else if (push_valid && push_ready) begin
      full <= 1'b1;
      head <= push_req;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_requester.sv
// mem_requester
// Processor-side initiator for the memoryModule port. Buffers one CPU
// load/store request, drives start/cntrl/addr/dataIn/isIndirect and holds
// them until dataReady, then returns dataOut as a one-cycle response.
// A saturating timer turns a stalled memory into an error response.
//
// Handshake: a CPU request transfers on a rising edge where
// reqValid & reqReady are both 1; reqReady does not depend on reqValid.
// Responses (rspValid) are single-cycle pulses with no backpressure.
//
// Ports:
//   clk, clr                  clock, asynchronous active-low reset
//   reqValid/reqReady         CPU request handshake
//   reqWrite, reqIndirect     1 = store / address is a pointer location
//   reqAddr, reqData          request address / store data
//   rspValid, rspData, rspErr response pulse, captured dataOut, timeout flag
//   busy                      FSM not idle
//   start, cntrl, isIndirect, addr, dataIn   to memoryModule
//   dataOut, dataReady        from memoryModule
//   fsm_state                 current FSM state (observability)
module mem_requester
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = REQ_ADDR_W,
  parameter int DATA_W  = REQ_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic              reqIndirect,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqData,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic              rspErr,
  output logic              busy,
  output logic              start,
  output logic [1:0]        cntrl,
  output logic              isIndirect,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dataIn,
  input  logic [DATA_W-1:0] dataOut,
  input  logic              dataReady,
  output state_t            fsm_state
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  req_t             push_req;
  req_t             head;
  logic             full;
  logic             pop;

  assign push_req = '{write: reqWrite, indirect: reqIndirect,
                      addr: reqAddr, data: reqData};

  // The FSM consumes the buffered request on the same edge it launches it.
  assign pop       = (state == ST_IDLE) && full;
  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

  req_buffer u_buf (
    .clk        (clk),
    .clr        (clr),
    .push_valid (reqValid),
    .push_ready (reqReady),
    .push_req   (push_req),
    .pop        (pop),
    .full       (full),
    .head       (head)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= ST_IDLE;
      timer      <= '0;
      start      <= 1'b0;
      cntrl      <= CNTRL_NOP;
      addr       <= '0;
      dataIn     <= '0;
      isIndirect <= 1'b0;
      rspValid   <= 1'b0;
      rspData    <= '0;
      rspErr     <= 1'b0;
    end else begin
      rspValid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (full) begin
            cntrl      <= head.write ? CNTRL_WRITE : CNTRL_READ;
            addr       <= head.addr;
            dataIn     <= head.data;
            isIndirect <= head.indirect;
            start      <= 1'b1;
            timer      <= '0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Memory-side outputs are untouched here so they stay stable.
          if (dataReady) begin
            rspData  <= dataOut;
            rspValid <= 1'b1;
            rspErr   <= 1'b0;
            start    <= 1'b0;
            cntrl    <= CNTRL_NOP;
            timer    <= '0;
            state    <= ST_RELEASE;
          end else if (timer == TMR_LAST) begin
            // Timer is left at its last value so RELEASE exits at once.
            rspData  <= '0;
            rspValid <= 1'b1;
            rspErr   <= 1'b1;
            start    <= 1'b0;
            cntrl    <= CNTRL_NOP;
            state    <= ST_RELEASE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_RELEASE: begin
          // Wait for the memory to drop dataReady so a held level is not
          // mistaken for the completion of the next operation.
          if (!dataReady || timer == TMR_LAST) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester
// Directed and randomized checks of mem_requester against a request-level
// reference: each accepted request is queued, must appear on the memory
// side with the expected cntrl/addr/dataIn/isIndirect, and must produce
// exactly one response carrying the value the memory model returned.
module tb_mem_requester;
  import mem_if_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              reqValid = 1'b0;
  logic              reqReady;
  logic              reqWrite = 1'b0;
  logic              reqIndirect = 1'b0;
  logic [ADDR_W-1:0] reqAddr = '0;
  logic [DATA_W-1:0] reqData = '0;
  logic              rspValid;
  logic [DATA_W-1:0] rspData;
  logic              rspErr;
  logic              busy;
  logic              start;
  logic [1:0]        cntrl;
  logic              isIndirect;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut = '0;
  logic              dataReady = 1'b0;
  state_t            fsm_state;

  int checks = 0;
  int errors = 0;

  // Expected queue of accepted requests: {write, indirect, addr, data}
  logic [17:0] req_q[$];
  logic [17:0] cur_req;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .clr        (clr),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqWrite   (reqWrite),
    .reqIndirect(reqIndirect),
    .reqAddr    (reqAddr),
    .reqData    (reqData),
    .rspValid   (rspValid),
    .rspData    (rspData),
    .rspErr     (rspErr),
    .busy       (busy),
    .start      (start),
    .cntrl      (cntrl),
    .isIndirect (isIndirect),
    .addr       (addr),
    .dataIn     (dataIn),
    .dataOut    (dataOut),
    .dataReady  (dataReady),
    .fsm_state  (fsm_state)
  );

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Offer a request until accepted (bounded); leaves the bench at the
  // sample point just after the accepting edge.
  task automatic send(input logic w, input logic ind, input logic [7:0] a, input logic [7:0] d);
    bit ok;
    ok = 0;
    reqValid = 1'b1; reqWrite = w; reqIndirect = ind; reqAddr = a; reqData = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (reqReady) begin
        ok = 1;
        req_q.push_back({w, ind, a, d});
      end
      step();
    end
    reqValid = 1'b0;
    chk("send_accept", ok, 1);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 10; i++) begin
      if (start) break;
      step();
    end
    chk("start_rise", start, 1);
  endtask

  task automatic take_req();
    chk("model_queue_nonempty", req_q.size() != 0, 1);
    if (req_q.size() != 0) cur_req = req_q.pop_front();
  endtask

  task automatic check_mem_side(input string tag);
    chk({tag, "_cntrl"}, cntrl, cur_req[17] ? 32'd2 : 32'd1);
    chk({tag, "_isind"}, isIndirect, cur_req[16]);
    chk({tag, "_addr"},  addr,       cur_req[15:8]);
    chk({tag, "_datain"}, dataIn,    cur_req[7:0]);
  endtask

  // Memory model: called at the sample where start is first seen.
  // Waits 'delay' cycles, raises dataReady with dout, keeps it up for
  // 'hold' cycles after the response; 'keep' leaves it raised at the end.
  task automatic serve(input int delay, input logic [7:0] dout, input int hold, input bit keep);
    take_req();
    check_mem_side("start");
    for (int k = 0; k < delay; k++) begin
      step();
      check_mem_side("stable");
      chk("stable_start", start, 1);
      chk("no_early_rsp", rspValid, 0);
    end
    dataReady = 1'b1;
    dataOut   = dout;
    step();
    chk("rsp_valid", rspValid, 1);
    chk("rsp_data",  rspData,  dout);
    chk("rsp_err",   rspErr,   0);
    chk("rsp_start_low", start, 0);
    chk("rsp_cntrl_nop", cntrl, 0);
    for (int k = 0; k < hold; k++) begin
      step();
      chk("sticky_no_rsp", rspValid, 0);
      chk("sticky_busy", busy, 1);
      chk("sticky_start_low", start, 0);
    end
    if (!keep) dataReady = 1'b0;
    dataOut = 8'($urandom_range(0, 255));
    step();
    chk("rsp_single", rspValid, 0);
    chk("release_done", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset values
    step(); step();
    chk("rst_reqready", reqReady, 1);
    chk("rst_start", start, 0);
    chk("rst_cntrl", cntrl, 0);
    chk("rst_addr", addr, 0);
    chk("rst_datain", dataIn, 0);
    chk("rst_isind", isIndirect, 0);
    chk("rst_rspvalid", rspValid, 0);
    chk("rst_rspdata", rspData, 0);
    chk("rst_rsperr", rspErr, 0);
    chk("rst_busy", busy, 0);
    clr = 1'b1;
    step();

    // Direct load: accept-to-start is one edge
    send(1'b0, 1'b0, 8'h3A, 8'h00);
    chk("accept_buf_full", reqReady, 0);
    chk("accept_no_start_yet", start, 0);
    step();
    chk("accept_to_start", start, 1);
    chk("popped_ready", reqReady, 1);
    chk("busy_high", busy, 1);
    serve(2, 8'hC5, 0, 0);

    // Indirect store
    send(1'b1, 1'b1, 8'h12, 8'hED);
    wait_start();
    serve(4, 8'h5A, 0, 0);

    // Back-to-back: second buffered, third stalls
    send(1'b0, 1'b1, 8'h40, 8'h11);
    wait_start();
    reqValid = 1'b1; reqWrite = 1'b1; reqIndirect = 1'b0; reqAddr = 8'h41; reqData = 8'h22;
    chk("b2b_second_ready", reqReady, 1);
    req_q.push_back({1'b1, 1'b0, 8'h41, 8'h22});
    step();
    reqAddr = 8'h42; reqData = 8'h33;
    for (int k = 0; k < 3; k++) begin
      chk("b2b_third_stalls", reqReady, 0);
      step();
    end
    reqValid = 1'b0;
    serve(0, 8'h99, 0, 0);
    chk("b2b_gap_start_low", start, 0);
    step();
    chk("b2b_start_two_after", start, 1);
    serve(1, 8'h77, 0, 0);

    // Sticky dataReady released by dropping it
    send(1'b0, 1'b0, 8'h55, 8'h00);
    wait_start();
    serve(1, 8'hA3, 5, 0);

    // Sticky dataReady released by the RELEASE timeout
    send(1'b0, 1'b0, 8'h56, 8'h00);
    wait_start();
    serve(0, 8'hB4, TIMEOUT - 1, 1);
    step();
    chk("sticky_idle_ignored_busy", busy, 0);
    chk("sticky_idle_ignored_rsp", rspValid, 0);
    dataReady = 1'b0;
    step();

    // Timeout: rspErr TIMEOUT cycles after start rose
    send(1'b1, 1'b0, 8'h77, 8'h88);
    wait_start();
    take_req();
    check_mem_side("to_start");
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      chk("to_no_rsp", rspValid, 0);
      chk("to_start_held", start, 1);
    end
    step();
    chk("to_rsp_valid", rspValid, 1);
    chk("to_rsp_err", rspErr, 1);
    chk("to_rsp_data", rspData, 0);
    chk("to_start_low", start, 0);
    step();
    chk("to_back_idle", busy, 0);
    chk("to_single_rsp", rspValid, 0);

    // Reset mid-BUSY with a buffered request
    send(1'b0, 1'b0, 8'h60, 8'h00);
    wait_start();
    reqValid = 1'b1; reqWrite = 1'b0; reqIndirect = 1'b0; reqAddr = 8'h61;
    step();
    reqValid = 1'b0;
    step();
    clr = 1'b0;
    #1;
    chk("midrst_start", start, 0);
    chk("midrst_reqready", reqReady, 1);
    chk("midrst_rspvalid", rspValid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", addr, 0);
    req_q.delete();
    step(); step();
    clr = 1'b1;
    dataReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("postrst_no_rsp", rspValid, 0);
      chk("postrst_no_start", start, 0);
    end
    dataReady = 1'b0;
    step();

    // Randomized traffic
    for (int n = 0; n < 25; n++) begin
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_start();
      serve(int'($urandom_range(0, 6)), 8'($urandom_range(0, 255)),
            int'($urandom_range(0, 3)), 0);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
